// File: rtl/dllp_pkg.sv
// -----------------------------------------------------------------------------
// dllp_pkg
// Shared definitions for DLLP framing on the receive path. The TX generator
// reuses the same items.
//   - DLLP byte-count constants
//   - receive FSM state encoding
//   - DLLP type codes carried in byte0
//   - CRC-16 byte-fold and final-field functions (poly 0x100B, seed 0xFFFF)
// -----------------------------------------------------------------------------
package dllp_pkg;

    localparam int DLLP_PAYLOAD_BYTES = 4;
    localparam int DLLP_CRC_BYTES     = 2;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

    localparam logic [7:0] DLLP_TYPE_NOP = 8'h31;
    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC0    = 2'd2,
        ST_CRC1    = 2'd3
    } dllp_state_e;

    // Fold one byte into the running CRC. The byte goes in bit0 first.
    function automatic logic [15:0] dllp_crc16_byte(input logic [15:0] crc_in,
                                                    input logic [7:0]  data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? DLLP_CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    // Turn the CRC register into the field carried on the wire: the register
    // is complemented and each byte is bit-reversed. The high byte goes first.
    function automatic logic [15:0] dllp_crc16_final(input logic [15:0] crc);
        logic [15:0] inv;
        logic [15:0] fld;
        inv = ~crc;
        for (int i = 0; i < 8; i++) begin
            fld[8 + i] = inv[15 - i];
            fld[i]     = inv[7 - i];
        end
        return fld;
    endfunction

endpackage

// File: rtl/dllp_crc16.sv
// -----------------------------------------------------------------------------
// dllp_crc16
// Byte-serial DLLP CRC-16 register. Shared by the RX assembler and the TX
// generator.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset; the register loads the seed
//   i_load  reload the seed (wins over i_adv)
//   i_adv   fold i_data into the register
//   i_data  byte to fold in
//   o_exp   expected 16-bit CRC field, in wire order, for the bytes folded so far
// -----------------------------------------------------------------------------
module dllp_crc16
    import dllp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_adv,
    input  logic [7:0]  i_data,
    output logic [15:0] o_exp
);

    logic [15:0] r_crc;

    // CRC register: seed on reset or load, fold on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= DLLP_CRC_SEED;
        end else if (i_load) begin
            r_crc <= DLLP_CRC_SEED;
        end else if (i_adv) begin
            r_crc <= dllp_crc16_byte(r_crc, i_data);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign o_exp = dllp_crc16_final(r_crc);

endmodule

// File: rtl/dllp_rx_assembler.sv
// -----------------------------------------------------------------------------
// dllp_rx_assembler
// Receive-side DLLP framing. It collects 4 payload bytes and 2 CRC bytes after
// each SDP token, checks the CRC, and presents good DLLPs as a 32-bit word with
// byte0 in [7:0].
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   rx_valid       a beat is present; when low, all state holds
//   rx_sdp         this beat is an SDP token (rx_data is ignored)
//   rx_data        DLLP byte
//   dllp_valid     1-cycle pulse: a good DLLP is on dllp_data
//   dllp_data      {byte3,byte2,byte1,byte0}; changes only on dllp_valid
//   dllp_crc_err   1-cycle pulse: a complete DLLP failed the CRC check
//   dllp_frag_err  1-cycle pulse: a DLLP was cut short by a new SDP
//   good_cnt       saturating count of dllp_valid pulses
//   bad_cnt        saturating count of crc_err and frag_err pulses
// -----------------------------------------------------------------------------
module dllp_rx_assembler
    import dllp_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic             rx_sdp,
    input  logic [7:0]       rx_data,
    output logic             dllp_valid,
    output logic [31:0]      dllp_data,
    output logic             dllp_crc_err,
    output logic             dllp_frag_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int               IDX_W    = $clog2(DLLP_PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DLLP_PAYLOAD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dllp_state_e      r_state;
    dllp_state_e      w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_buf;
    logic [7:0]       r_crc_hi;
    logic [31:0]      r_dllp_data;
    logic             r_valid;
    logic             r_crc_err;
    logic             r_frag_err;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_bad_cnt;

    logic             w_crc_load;
    logic             w_crc_adv;
    logic             w_good_evt;
    logic             w_crc_evt;
    logic             w_frag_evt;
    logic [15:0]      w_exp;

    dllp_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_crc_load),
        .i_adv  (w_crc_adv),
        .i_data (rx_data),
        .o_exp  (w_exp)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-beat events. An SDP beat always wins over the byte
    // the current state expects, including the CRC1 byte.
    always_comb begin
        w_state_nxt = r_state;
        w_crc_load  = 1'b0;
        w_crc_adv   = 1'b0;
        w_good_evt  = 1'b0;
        w_crc_evt   = 1'b0;
        w_frag_evt  = 1'b0;
        if (rx_valid) begin
            if (rx_sdp) begin
                w_crc_load  = 1'b1;
                w_state_nxt = ST_PAYLOAD;
                w_frag_evt  = (r_state != ST_IDLE);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_IDLE;
                    end
                    ST_PAYLOAD: begin
                        w_crc_adv = 1'b1;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_CRC0;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                    ST_CRC0: begin
                        w_state_nxt = ST_CRC1;
                    end
                    ST_CRC1: begin
                        w_state_nxt = ST_IDLE;
                        if (!CHECK_CRC || ({r_crc_hi, rx_data} == w_exp)) begin
                            w_good_evt = 1'b1;
                        end else begin
                            w_crc_evt = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath: payload staging, captured CRC high byte, published word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_buf       <= 32'h0000_0000;
            r_crc_hi    <= 8'h00;
            r_dllp_data <= 32'h0000_0000;
        end else begin
            if (rx_valid && rx_sdp) begin
                r_idx <= '0;
            end else if (w_crc_adv) begin
                r_buf[{r_idx, 3'b000} +: 8] <= rx_data;
                r_idx                       <= r_idx + 1'b1;
            end else if (rx_valid && (r_state == ST_CRC0)) begin
                r_crc_hi <= rx_data;
            end
            // r_buf is complete by the CRC1 beat; publish only a good DLLP.
            if (w_good_evt) begin
                r_dllp_data <= r_buf;
            end
        end
    end

    // Output pulses and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_crc_err  <= 1'b0;
            r_frag_err <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_valid    <= w_good_evt;
            r_crc_err  <= w_crc_evt;
            r_frag_err <= w_frag_evt;
            if (w_good_evt && (r_good_cnt != '1)) begin
                r_good_cnt <= r_good_cnt + CNT_ONE;
            end
            if ((w_crc_evt || w_frag_evt) && (r_bad_cnt != '1)) begin
                r_bad_cnt <= r_bad_cnt + CNT_ONE;
            end
        end
    end

    assign dllp_valid    = r_valid;
    assign dllp_data     = r_dllp_data;
    assign dllp_crc_err  = r_crc_err;
    assign dllp_frag_err = r_frag_err;
    assign good_cnt      = r_good_cnt;
    assign bad_cnt       = r_bad_cnt;

endmodule

// File: tb/tb_dllp_rx_assembler.sv
// -----------------------------------------------------------------------------
// tb_dllp_rx_assembler
// Directed bench for dllp_rx_assembler. dut uses the default parameters.
// dut_sat uses CNT_W=2 and shares the same input stream, so counter
// saturation can be observed on it.
// -----------------------------------------------------------------------------
module tb_dllp_rx_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic        rx_sdp;
    logic [7:0]  rx_data;

    logic        dllp_valid;
    logic [31:0] dllp_data;
    logic        dllp_crc_err;
    logic        dllp_frag_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    logic        s_valid;
    logic [31:0] s_data;
    logic        s_crc_err;
    logic        s_frag_err;
    logic [1:0]  s_good_cnt;
    logic [1:0]  s_bad_cnt;

    int checks = 0;
    int errors = 0;

    int n_valid = 0;
    int n_crc   = 0;
    int n_frag  = 0;
    int n_valid_sat = 0;

    always #5 clk = ~clk;

    dllp_rx_assembler #(.CNT_W(16), .CHECK_CRC(1'b1)) dut (
        .clk (clk), .rst (rst), .rx_valid (rx_valid), .rx_sdp (rx_sdp),
        .rx_data (rx_data), .dllp_valid (dllp_valid), .dllp_data (dllp_data),
        .dllp_crc_err (dllp_crc_err), .dllp_frag_err (dllp_frag_err),
        .good_cnt (good_cnt), .bad_cnt (bad_cnt)
    );

    dllp_rx_assembler #(.CNT_W(2), .CHECK_CRC(1'b1)) dut_sat (
        .clk (clk), .rst (rst), .rx_valid (rx_valid), .rx_sdp (rx_sdp),
        .rx_data (rx_data), .dllp_valid (s_valid), .dllp_data (s_data),
        .dllp_crc_err (s_crc_err), .dllp_frag_err (s_frag_err),
        .good_cnt (s_good_cnt), .bad_cnt (s_bad_cnt)
    );

    // Count output pulses. Outputs change on posedge, so sample on negedge.
    always @(negedge clk) begin
        if (dllp_valid)    n_valid     <= n_valid + 1;
        if (dllp_crc_err)  n_crc       <= n_crc + 1;
        if (dllp_frag_err) n_frag      <= n_frag + 1;
        if (s_valid)       n_valid_sat <= n_valid_sat + 1;
    end

    // Reference CRC field for a payload word (byte0 in [7:0]). It is written
    // independently of the RTL package.
    function automatic logic [15:0] ref_crc(input logic [31:0] w);
        logic [15:0] c;
        logic [15:0] x;
        logic [15:0] f;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < 32; k++) begin
            fb = c[15] ^ w[k];
            c  = (c << 1) ^ (fb ? 16'h100B : 16'h0000);
        end
        x = ~c;
        for (int i = 0; i < 8; i++) begin
            f[15 - i] = x[8 + i];
            f[7 - i]  = x[i];
        end
        return f;
    endfunction

    task automatic beat(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_sdp   = s;
        rx_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
    endtask

    // SDP, 4 payload bytes, 2 CRC bytes, with 'gap' idle cycles between beats.
    // crc_xor is applied to the second CRC byte. The task returns after the
    // final byte has been driven.
    task automatic send_dllp(input logic [31:0] w, input logic [7:0] crc_xor,
                             input int gap);
        logic [15:0] f;
        f = ref_crc(w);
        beat(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            idle(gap);
            beat(1'b1, 1'b0, w[8*i +: 8]);
        end
        idle(gap);
        beat(1'b1, 1'b0, f[15:8]);
        idle(gap);
        beat(1'b1, 1'b0, f[7:0] ^ crc_xor);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; rx_sdp = 1'b0; rx_data = 8'h00;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dllp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dllp_valid); end
        checks++;
        if (dllp_crc_err !== 1'b0 || dllp_frag_err !== 1'b0) begin
            errors++; $display("FAIL reset_errs got %b%b want 00", dllp_crc_err, dllp_frag_err);
        end
        checks++;
        if (dllp_data !== 32'h0000_0000) begin errors++; $display("FAIL reset_data got %h want 00000000", dllp_data); end
        checks++;
        if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnts got %0d/%0d want 0/0", good_cnt, bad_cnt);
        end
    endtask

    task automatic test_good_nop();
        send_dllp(32'hCCBB_AA31, 8'h00, 0);
        idle(1);
        checks++;
        if (dllp_valid !== 1'b1 || dllp_crc_err !== 1'b0 || dllp_frag_err !== 1'b0) begin
            errors++; $display("FAIL nop_pulse got v=%b c=%b f=%b want 1 0 0", dllp_valid, dllp_crc_err, dllp_frag_err);
        end
        checks++;
        if (dllp_data !== 32'hCCBB_AA31) begin errors++; $display("FAIL nop_data got %h want ccbbaa31", dllp_data); end
        checks++;
        if (good_cnt !== 16'd1) begin errors++; $display("FAIL nop_good_cnt got %0d want 1", good_cnt); end
        idle(1);
        checks++;
        if (dllp_valid !== 1'b0) begin errors++; $display("FAIL nop_one_cycle got %b want 0", dllp_valid); end
    endtask

    task automatic test_crc_err();
        send_dllp(32'hCCBB_AA31, 8'h01, 0);
        idle(1);
        checks++;
        if (dllp_crc_err !== 1'b1 || dllp_valid !== 1'b0 || dllp_frag_err !== 1'b0) begin
            errors++; $display("FAIL crc_pulse got c=%b v=%b f=%b want 1 0 0", dllp_crc_err, dllp_valid, dllp_frag_err);
        end
        checks++;
        if (dllp_data !== 32'hCCBB_AA31) begin errors++; $display("FAIL crc_data_kept got %h want ccbbaa31", dllp_data); end
        checks++;
        if (bad_cnt !== 16'd1 || good_cnt !== 16'd1) begin
            errors++; $display("FAIL crc_cnts got good=%0d bad=%0d want 1/1", good_cnt, bad_cnt);
        end
        idle(1);
        checks++;
        if (dllp_crc_err !== 1'b0) begin errors++; $display("FAIL crc_one_cycle got %b want 0", dllp_crc_err); end
    endtask

    task automatic test_gaps();
        int v0;
        do_reset();
        v0 = n_valid;
        send_dllp(32'h0500_0000, 8'h00, 3);
        idle(1);
        checks++;
        if (dllp_valid !== 1'b1) begin errors++; $display("FAIL gap_latency got %b want 1", dllp_valid); end
        checks++;
        if (dllp_data !== 32'h0500_0000) begin errors++; $display("FAIL gap_data got %h want 05000000", dllp_data); end
        idle(2);
        checks++;
        if (n_valid - v0 !== 1) begin errors++; $display("FAIL gap_count got %0d want 1", n_valid - v0); end
    endtask

    task automatic test_frag();
        int v0, c0, f0;
        do_reset();
        v0 = n_valid; c0 = n_crc; f0 = n_frag;
        beat(1'b1, 1'b1, 8'h00);
        beat(1'b1, 1'b0, 8'h31);
        beat(1'b1, 1'b0, 8'hAA);
        send_dllp(32'h0700_0010, 8'h00, 0);
        idle(3);
        checks++;
        if (n_frag - f0 !== 1 || n_crc - c0 !== 0) begin
            errors++; $display("FAIL frag_pulses got frag=%0d crc=%0d want 1/0", n_frag - f0, n_crc - c0);
        end
        checks++;
        if (n_valid - v0 !== 1 || dllp_data !== 32'h0700_0010) begin
            errors++; $display("FAIL frag_next got n=%0d data=%h want 1 07000010", n_valid - v0, dllp_data);
        end
        checks++;
        if (good_cnt !== 16'd1 || bad_cnt !== 16'd1) begin
            errors++; $display("FAIL frag_cnts got good=%0d bad=%0d want 1/1", good_cnt, bad_cnt);
        end
    endtask

    // SDP arriving on the beat that would have been CRC1.
    task automatic test_sdp_on_crc1();
        int v0, c0, f0;
        logic [15:0] f;
        do_reset();
        v0 = n_valid; c0 = n_crc; f0 = n_frag;
        f = ref_crc(32'h4433_2211);
        beat(1'b1, 1'b1, 8'h00);
        beat(1'b1, 1'b0, 8'h11);
        beat(1'b1, 1'b0, 8'h22);
        beat(1'b1, 1'b0, 8'h33);
        beat(1'b1, 1'b0, 8'h44);
        beat(1'b1, 1'b0, f[15:8]);
        beat(1'b1, 1'b1, f[7:0]);
        idle(1);
        checks++;
        if (dllp_frag_err !== 1'b1 || dllp_valid !== 1'b0 || dllp_crc_err !== 1'b0) begin
            errors++; $display("FAIL sdp_crc1_pulse got f=%b v=%b c=%b want 1 0 0", dllp_frag_err, dllp_valid, dllp_crc_err);
        end
        // The SDP beat restarted framing: these payload bytes and CRC complete a good DLLP.
        f = ref_crc(32'h0000_0031);
        beat(1'b1, 1'b0, 8'h31);
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b1, 1'b0, f[15:8]);
        beat(1'b1, 1'b0, f[7:0]);
        idle(3);
        checks++;
        if (n_valid - v0 !== 1 || n_frag - f0 !== 1 || n_crc - c0 !== 0 || dllp_data !== 32'h0000_0031) begin
            errors++; $display("FAIL sdp_crc1_restart got v=%0d f=%0d c=%0d data=%h want 1 1 0 00000031",
                               n_valid - v0, n_frag - f0, n_crc - c0, dllp_data);
        end
    endtask

    task automatic test_reset_mid();
        int v0, c0, f0;
        do_reset();
        v0 = n_valid; c0 = n_crc; f0 = n_frag;
        beat(1'b1, 1'b1, 8'h00);
        beat(1'b1, 1'b0, 8'h31);
        beat(1'b1, 1'b0, 8'hAA);
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; rx_sdp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        checks++;
        if (n_crc - c0 !== 0 || n_frag - f0 !== 0 || n_valid - v0 !== 0) begin
            errors++; $display("FAIL rstmid_pulses got v=%0d c=%0d f=%0d want 0 0 0", n_valid - v0, n_crc - c0, n_frag - f0);
        end
        checks++;
        if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_cnts got %0d/%0d want 0/0", good_cnt, bad_cnt);
        end
        send_dllp(32'h0000_0031, 8'h00, 0);
        idle(3);
        checks++;
        if (good_cnt !== 16'd1 || bad_cnt !== 16'd0 || dllp_data !== 32'h0000_0031) begin
            errors++; $display("FAIL rstmid_after got good=%0d bad=%0d data=%h want 1 0 00000031", good_cnt, bad_cnt, dllp_data);
        end
    endtask

    task automatic test_saturation();
        int s0;
        do_reset();
        s0 = n_valid_sat;
        send_dllp(32'h0000_0031, 8'h00, 0);
        send_dllp(32'h0000_0000, 8'h00, 0);
        send_dllp(32'h0000_0010, 8'h00, 0);
        send_dllp(32'h1234_5631, 8'h00, 0);
        send_dllp(32'hFFFF_FF31, 8'h00, 0);
        idle(3);
        checks++;
        if (s_good_cnt !== 2'd3) begin errors++; $display("FAIL sat_good_cnt got %0d want 3", s_good_cnt); end
        checks++;
        if (n_valid_sat - s0 !== 5) begin errors++; $display("FAIL sat_pulses got %0d want 5", n_valid_sat - s0); end
        checks++;
        if (good_cnt !== 16'd5 || s_data !== 32'hFFFF_FF31) begin
            errors++; $display("FAIL sat_wide got cnt=%0d data=%h want 5 ffffff31", good_cnt, s_data);
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_sdp = 1'b0; rx_data = 8'h00;
        test_reset();
        test_good_nop();
        test_crc_err();
        test_gaps();
        test_frag();
        test_sdp_on_crc1();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
